fir_mac_sequencer: RTL and testbench

- Control unit for the single-MAC FIR datapath (delay line, coefficient memory, accumulator, output register).
- Accepts one sample per valid/ready handshake, sweeps the tap address over all TAPS taps, and gates accumulation through a configurable read pipeline.
- Loads the output register, then holds out_valid until downstream consumes the result.
- Sits between the sample source/sink and the FIR datapath; replaces ad-hoc counter and clear control.

---
 rtl/fir_seq_pkg.sv | 21 ++
 rtl/fir_tap_counter.sv | 26 ++
 rtl/fir_mac_sequencer.sv | 145 ++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the FIR MAC sequencer and its tap counter.
package fir_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    LOAD,
    DONE
  } state_t;

  // Deepest coefficient/operand read pipeline the sequencer can gate.
  localparam int LAT_MAX = 4;

  // Compare against TAPS-1 rather than relying on a power-of-two rollover,
  // so odd tap counts terminate correctly.
  function automatic logic tap_is_last(input int count, input int taps);
    return count == (taps - 1);
  endfunction

endpackage

// File: rtl/fir_tap_counter.sv
// Tap index counter: counts 0..TAPS-1 while enabled, wraps to 0 after the last tap.
module fir_tap_counter
  import fir_seq_pkg::*;
#(
  parameter int TAPS   = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  assign tc = tap_is_last(int'(count), TAPS);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control FSM for a single-MAC FIR datapath: accept, tap sweep, drain, load, hold.
// Optional macro FIR_SEQ_BACK2BACK_EN lets a new sample be accepted in the result handshake cycle.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int TAPS   = 64,
  parameter int ADDR_W = 6,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              smp_wr_en,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              out_ld,
  output logic              busy,
  output state_t            state_dbg
);

  // Handshakes: a transfer happens in a cycle where valid && ready are both
  // high at the rising edge; valid, once raised, is held until that transfer.

  localparam int LAT_EFF = (LAT > LAT_MAX) ? LAT_MAX : LAT;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] tap_cnt;
  logic              tap_tc;
  logic              accept;
  logic              mac_flag;
  logic              acc_en_raw;
  logic              pipe_drained;
  logic              in_ready_c;
  logic              out_valid_c;
  logic              out_ld_c;

  assign mac_flag = (state == MAC);

  fir_tap_counter #(
    .TAPS  (TAPS),
    .ADDR_W(ADDR_W)
  ) u_tap_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (mac_flag),
    .count(tap_cnt),
    .tc   (tap_tc)
  );

  // The MAC flag travels alongside the operand read so acc_en lines up with
  // the operands reaching the multiplier.
  if (LAT_EFF == 0) begin : g_no_lat
    assign acc_en_raw   = mac_flag;
    assign pipe_drained = 1'b1;
  end else begin : g_lat
    localparam logic [LAT_EFF-1:0] LAST_ONLY = LAT_EFF'(1 << (LAT_EFF - 1));
    logic [LAT_EFF-1:0] mac_pipe;

    always_ff @(posedge clk) begin
      if (rst) begin
        mac_pipe <= '0;
      end else begin
        mac_pipe <= LAT_EFF'({mac_pipe, mac_flag});
      end
    end

    assign acc_en_raw   = mac_pipe[LAT_EFF-1];
    // Only the final stage still carries a tap: this is the last accumulate.
    assign pipe_drained = (mac_pipe == LAST_ONLY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    out_ld_c    = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = MAC;
        end
      end
      MAC: begin
        if (tap_tc) begin
          state_nx = (LAT_EFF == 0) ? LOAD : DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_drained) begin
          state_nx = LOAD;
        end
      end
      LOAD: begin
        out_ld_c = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
`ifdef FIR_SEQ_BACK2BACK_EN
        // out_ld of this result already happened, so clearing the
        // accumulator for the next sample in the same cycle is safe.
        in_ready_c = out_ready;
        if (out_ready) begin
          accept   = in_valid;
          state_nx = in_valid ? MAC : IDLE;
        end
`else
        if (out_ready) begin
          state_nx = IDLE;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are forced quiet for the whole reset cycle, not just after it.
  assign in_ready  = in_ready_c & ~rst;
  assign out_valid = out_valid_c & ~rst;
  assign out_ld    = out_ld_c & ~rst;
  assign smp_wr_en = accept & ~rst;
  assign acc_clr   = accept & ~rst;
  assign acc_en    = acc_en_raw & ~rst;
  assign busy      = (state != IDLE) & ~rst;
  assign coef_addr = (mac_flag && !rst) ? tap_cnt : '0;
  assign state_dbg = state;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: three configurations checked against a transaction timeline model.
module tb_fir_mac_sequencer;
  import fir_seq_pkg::*;

`ifdef FIR_SEQ_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  localparam int NCFG = 3;

  // clock / reset
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NCFG-1:0] iv  = '0;
  logic [NCFG-1:0] orr = '0;
  int              cyc = 0;
  int              n_checks = 0;
  int              n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
  endtask

  task automatic drive(input logic r, input logic [NCFG-1:0] v, input logic [NCFG-1:0] o);
    @(posedge clk);
    #1;
    rst = r;
    iv  = v;
    orr = o;
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int T  = (g == 0) ? 64 : 5;
    localparam int L  = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    localparam int AW = (g == 0) ? 6 : 3;

    logic          in_ready, out_valid, smp_wr_en, acc_clr, acc_en, out_ld, busy;
    logic [AW-1:0] coef_addr;
    state_t        state_dbg;

    fir_mac_sequencer #(.TAPS(T), .ADDR_W(AW), .LAT(L)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[g]),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_ready(orr[g]),
      .smp_wr_en(smp_wr_en),
      .acc_clr  (acc_clr),
      .acc_en   (acc_en),
      .coef_addr(coef_addr),
      .out_ld   (out_ld),
      .busy     (busy),
      .state_dbg(state_dbg)
    );

    // Reference: t counts cycles since the accepting handshake (t=0).
    bit          active = 1'b0;
    int          t = 0;
    int          acc_pulses = 0;
    logic        prev_ov = 1'b0;
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
      bit e_ir, e_ov, e_acc, e_ae, e_ld, e_busy;
      int ea;
      e_ir = 0; e_ov = 0; e_acc = 0; e_ae = 0; e_ld = 0; e_busy = 0; ea = 0;
      if (rst) begin
        active = 1'b0;
        exp_q.delete();
        acc_pulses = 0;
      end else if (!active) begin
        e_ir  = 1'b1;
        e_acc = iv[g];
      end else begin
        e_busy = 1'b1;
        if (t <= T) ea = t - 1;
        e_ae  = (t >= 1 + L) && (t <= T + L);
        e_ld  = (t == T + L + 1);
        e_ov  = (t >= T + L + 2);
        e_ir  = B2B && e_ov && orr[g];
        e_acc = e_ir && iv[g];
      end

      check($sformatf("c%0d ctl", g),
            32'({in_ready, out_valid, smp_wr_en, acc_clr, acc_en, out_ld, busy}),
            32'({e_ir, e_ov, e_acc, e_acc, e_ae, e_ld, e_busy}));
      check($sformatf("c%0d coef_addr", g), 32'(coef_addr), 32'(ea));
      if (!rst) check($sformatf("c%0d idle_dbg", g), 32'(state_dbg == IDLE), 32'(!e_busy));

      if (!rst) begin
        if (out_valid && !prev_ov) begin
          check($sformatf("c%0d result_pending", g), 32'(exp_q.size() > 0), 32'(1));
          if (exp_q.size() > 0) check($sformatf("c%0d latency", g), 32'(cyc), exp_q.pop_front());
        end
        if (acc_en) acc_pulses++;
        if (out_ld) begin
          check($sformatf("c%0d acc_pulses", g), 32'(acc_pulses), 32'(T));
          acc_pulses = 0;
        end
        if (e_acc) exp_q.push_back(32'(cyc + T + L + 2));
        if (active && e_ov && orr[g]) begin
          if (e_acc) t = 1;
          else active = 1'b0;
        end else if (active) begin
          t++;
        end else if (e_acc) begin
          active = 1'b1;
          t = 1;
        end
      end
      prev_ov = out_valid;
    end
  end

  // stimulus
  initial begin
    bit found;
    repeat (3) drive(1'b1, '0, '0);
    // continuous streaming with downstream always ready
    repeat (160) drive(1'b0, '1, '1);
    // downstream stalled while upstream pokes in_valid
    repeat (90) drive(1'b0, NCFG'($urandom), '0);
    repeat (20) drive(1'b0, '0, '1);
    // random traffic with occasional resets
    repeat (3000) drive(1'($urandom_range(0, 399) == 0), NCFG'($urandom), NCFG'($urandom));
    // abort configuration 0 in the middle of its tap sweep
    drive(1'b1, '0, '1);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, '1, '1);
      if (g_cfg[0].coef_addr == 6'd30) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached", 32'(found), 32'(1));
    rst = 1'b1;
    repeat (200) drive(1'b0, '1, '1);
    repeat (100) drive(1'b0, '0, '1);
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
